// File: rtl/div_seq.sv
// div_seq: radix-2 restoring DIV/DIVU sequencer producing hi=remainder, lo=quotient
module div_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              annul_i,
  output logic              stall_o,
  output logic              ready_o,
  output logic [DATA_W-1:0] result_hi_o,
  output logic [DATA_W-1:0] result_lo_o
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] abs_a, abs_b, rem_n, quo_n;
  logic [DATA_W:0] trial;
  logic negq_q, negq_d, negr_q, negr_d, ready_q, ready_d, go;
  assign go = start_i & ~annul_i;
  assign abs_a = (signed_i & dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
  assign abs_b = (signed_i & divisor_i[DATA_W-1]) ? -divisor_i : divisor_i;
  assign trial = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvs_q};
  assign rem_n = trial[DATA_W] ? {rem_q[DATA_W-2:0], quo_q[DATA_W-1]} : trial[DATA_W-1:0];
  assign quo_n = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
  assign stall_o = (state_q == IDLE & go) | state_q == RUN | state_q == BYZERO;
  assign ready_o = ready_q;
  assign result_hi_o = hi_q;
  assign result_lo_o = lo_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      ready_q <= ready_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    hi_d = hi_q;
    lo_d = lo_q;
    negq_d = negq_q;
    negr_d = negr_q;
    ready_d = ready_q;
    unique case (state_q)
      IDLE: if (go) begin
        state_d = divisor_i == '0 ? BYZERO : RUN;
        cnt_d = '0;
        rem_d = '0;
        quo_d = abs_a;
        dvs_d = abs_b;
        negq_d = signed_i & (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
        negr_d = signed_i & dividend_i[DATA_W-1];
      end
      RUN: if (annul_i) state_d = IDLE;
      else begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d = DONE;
          ready_d = 1'b1;
          hi_d = negr_q ? -rem_n : rem_n;
          lo_d = negq_q ? -quo_n : quo_n;
        end
      end
      BYZERO: if (annul_i) state_d = IDLE;
      else begin
        state_d = DONE;
        ready_d = 1'b1;
        hi_d = '0;
        lo_d = '0;
      end
      DONE: if (annul_i | ~start_i) begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle divide sequencer for the execute stage.
- Runs DIV/DIVU over DATA_W cycles using radix-2 restoring division.
- Stalls the pipeline while busy, then presents the remainder/quotient pair that the execute stage forwards as the HI/LO write (hi = remainder, lo = quotient).
- Owns the only long-latency write path into the HI/LO registers; supports cancellation on pipeline flush.

Parameters:
DATA_W, 32, operand width; the result is 2*DATA_W.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  reset_status_t  synchronous, active-high (RST_ENABLE); IDLE and all outputs cleared
start_i  input  1  divide request from EX; held high until ready_o is seen
signed_i  input  1  1 = DIV (two's complement), 0 = DIVU
dividend_i  input  DATA_W  opdata1
divisor_i  input  DATA_W  opdata2
annul_i  input  1  flush/exception; cancels any operation in progress
stall_o  output  1  pipeline stall request (combinational)
ready_o  output  1  result valid (registered)
result_hi_o  output  DATA_W  remainder (registered)
result_lo_o  output  DATA_W  quotient (registered)

Behaviour:
- States: IDLE, BYZERO, RUN, DONE. Reset (rst==RST_ENABLE at clock edge) forces IDLE, ready_o=0, result_hi_o=0, result_lo_o=0 from any state, including mid-RUN.
- IDLE:
  - start_i=1 and annul_i=0, divisor_i==0: go to BYZERO.
  - start_i=1 and annul_i=0, divisor_i!=0: go to RUN. Latch sign flags (dividend MSB, divisor MSB, signed_i). Latch operand magnitudes: the two's-complement absolute value when signed_i=1, raw otherwise. Clear the partial remainder and set the iteration counter to 0.
  - Otherwise: stay in IDLE.
- RUN: each cycle performs one iteration:
  - Shift {rem, quo} left 1, bringing in the next dividend bit.
  - Compute the trial difference = rem − divisor magnitude (DATA_W+1 bits).
  - If the difference is non-negative, rem takes the difference and the quotient bit is 1; otherwise rem is kept and the quotient bit is 0.
  - The counter increments. After the iteration with counter == DATA_W−1, go to DONE.
- Entering DONE from RUN, results are registered with sign correction:
  - Quotient is negated iff signed_i and dividend sign != divisor sign.
  - Remainder is negated iff signed_i and the dividend is negative.
  - ready_o=1.
- BYZERO: next cycle go to DONE with result_hi_o=0, result_lo_o=0, ready_o=1. No trap is raised.
- DONE:
  - ready_o stays 1 and results stay stable while start_i=1.
  - start_i=0: go to IDLE, ready_o=0 next cycle. Results hold their last value.
- annul_i=1 in RUN, BYZERO or DONE: go to IDLE next cycle, ready_o=0, results are not updated by the cancelled operation.
- stall_o = (state==IDLE & start_i & ~annul_i) | state==RUN | state==BYZERO. It is 0 in DONE so the instruction retires in the cycle ready_o=1 is seen.
- Latency, counting from the edge where start_i is sampled in IDLE:
  - ready_o is high in the cycle after DATA_W RUN cycles, i.e. cycle DATA_W+1 (33 at default).
  - Divide by zero: ready_o high at cycle 2.
- Arithmetic: the magnitude path is unsigned DATA_W bits; the trial subtract is DATA_W+1 bits. The most-negative value's magnitude is 2^(DATA_W−1) unsigned, which is correct. Overflow 0x80000000 / −1 signed yields quotient 0x80000000, remainder 0 (wrap, no exception).
- Back-to-back: a new start_i is accepted only in IDLE, so at least one IDLE cycle separates operations.

Test Plan:
- DIVU 100 / 7, start_i held → stall_o=1 for cycles 0..32, ready_o=1 at cycle 33, hi=2, lo=14; drop start_i → ready_o=0 next cycle.
- DIV −7 / 2 (0xFFFFFFF9, 0x2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7 / −2 → lo=0xFFFFFFFD, hi=1. DIVU 0xFFFFFFF9 / 2 → lo=0x7FFFFFFC, hi=1.
- Divisor 0 (either signedness) → BYZERO, ready_o=1 at cycle 2, hi=lo=0, stall_o low in DONE.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. DIVU 0xFFFFFFFF / 1 → lo=0xFFFFFFFF, hi=0.
- Start DIVU 50/5, assert annul_i at cycle 10 → IDLE at cycle 11, ready_o never rises, results unchanged. A following DIVU 9/4 completes with lo=2, hi=1 at the expected latency.
- Assert rst at cycle 15 of a RUN → next cycle state IDLE, ready_o=0, hi=lo=0, stall_o=0 with start_i low. A fresh start completes normally.
